// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch/decoder handshake and instruction memory bus bundle
// Optional retire_cnt signal is present when IFETCH_RETIRE_CNT_EN is defined.
interface instr_fetch_if;
  logic        cnt_en;
  logic        pc_sload;
  logic [15:0] new_pc;
  logic [15:0] instr_addr1;
  logic [15:0] instr_addr2;
  logic        stall;
  logic [15:0] rdata1;
  logic [15:0] rdata2;
  logic [15:0] mem_addr1;
  logic [15:0] mem_addr2;
  logic [15:0] pc;
  logic [15:0] instr;
  logic [15:0] n_word;
  logic        instr_valid;
  logic        halted;
`ifdef IFETCH_RETIRE_CNT_EN
  logic [31:0] retire_cnt;

  modport master (
    output cnt_en, pc_sload, new_pc, instr_addr1, instr_addr2, stall, rdata1, rdata2,
    input  mem_addr1, mem_addr2, pc, instr, n_word, instr_valid, halted, retire_cnt
  );
  modport slave (
    input  cnt_en, pc_sload, new_pc, instr_addr1, instr_addr2, stall, rdata1, rdata2,
    output mem_addr1, mem_addr2, pc, instr, n_word, instr_valid, halted, retire_cnt
  );
`else
  modport master (
    output cnt_en, pc_sload, new_pc, instr_addr1, instr_addr2, stall, rdata1, rdata2,
    input  mem_addr1, mem_addr2, pc, instr, n_word, instr_valid, halted
  );
  modport slave (
    input  cnt_en, pc_sload, new_pc, instr_addr1, instr_addr2, stall, rdata1, rdata2,
    output mem_addr1, mem_addr2, pc, instr, n_word, instr_valid, halted
  );
`endif
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC register and WAIT/EXEC/HALT instruction fetch sequencer
// Optional retired-instruction counter enabled by IFETCH_RETIRE_CNT_EN.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  instr_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'b00,
    ST_EXEC = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT);

  state_t      state_q,    state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] pc_q,       pc_d;
  logic [15:0] addr1_q,    addr1_d;
  logic [15:0] addr2_q,    addr2_d;
  logic [15:0] instr_q,    instr_d;
  logic [15:0] n_word_q,   n_word_d;
  logic        instr_valid;
  logic        is_stp;
`ifdef IFETCH_RETIRE_CNT_EN
  logic [31:0] retire_q,   retire_d;
`endif

  assign is_stp = (instr_q[15:11] == 5'b11111);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pc_d        = pc_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    instr_d     = instr_q;
    n_word_d    = n_word_q;
    instr_valid = 1'b0;
`ifdef IFETCH_RETIRE_CNT_EN
    retire_d    = retire_q;
`endif
    case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          instr_d  = bus.rdata1;
          n_word_d = bus.rdata2;
          state_d  = ST_EXEC;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      ST_EXEC: begin
        instr_valid = !bus.stall;
        if (!bus.stall) begin
`ifdef IFETCH_RETIRE_CNT_EN
          if (retire_q != 32'hFFFF_FFFF) retire_d = retire_q + 32'd1;
`endif
          if (is_stp) begin
            state_d = ST_HALT;
          end else begin
            // Load wins over increment when the decoder asserts both.
            if (bus.pc_sload)    pc_d = bus.new_pc;
            else if (bus.cnt_en) pc_d = pc_q + 16'd1;
            addr1_d    = bus.instr_addr1;
            addr2_d    = bus.instr_addr2;
            wait_cnt_d = WAIT_INIT;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_WAIT;
      wait_cnt_q <= WAIT_INIT;
      pc_q       <= RESET_PC;
      addr1_q    <= RESET_PC;
      addr2_q    <= RESET_PC + 16'd1;
      instr_q    <= 16'h0000;
      n_word_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pc_q       <= pc_d;
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      instr_q    <= instr_d;
      n_word_q   <= n_word_d;
    end
  end

`ifdef IFETCH_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_q <= 32'd0;
    else        retire_q <= retire_d;
  end

  assign bus.retire_cnt = retire_q;
`endif

  assign bus.mem_addr1   = addr1_q;
  assign bus.mem_addr2   = addr2_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.n_word      = n_word_q;
  assign bus.instr_valid = instr_valid;
  assign bus.halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a transaction-level fetch model
module tb_instr_fetch;

  localparam logic [15:0] RST_PC = 16'h0010;
`ifdef IFETCH_RETIRE_CNT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(RST_PC), .MEM_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Instruction memory with LAT edges of read latency on both ports.
  logic [15:0] mem [0:65535];
  logic [15:0] p1 [LAT];
  logic [15:0] p2 [LAT];

  always @(posedge clk) begin
    p1[0] <= mem[bus.mem_addr1];
    p2[0] <= mem[bus.mem_addr2];
    for (int k = 1; k < LAT; k++) begin
      p1[k] <= p1[k-1];
      p2[k] <= p2[k-1];
    end
  end

  assign bus.rdata1 = p1[LAT-1];
  assign bus.rdata2 = p2[LAT-1];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: architectural view of what the decoder should be seeing.
  logic [15:0] m_pc, m_a1, m_a2, m_instr, m_n;
  int          m_retire;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  task automatic drive_junk(input logic with_stall);
    bus.cnt_en      = 1'($urandom);
    bus.pc_sload    = 1'($urandom);
    bus.new_pc      = 16'($urandom);
    bus.instr_addr1 = 16'($urandom);
    bus.instr_addr2 = 16'($urandom);
    bus.stall       = with_stall ? 1'($urandom) : 1'b0;
  endtask

  task automatic check_arch(input string tag);
    chk({tag, "_pc"},    {16'h0, bus.pc},        {16'h0, m_pc});
    chk({tag, "_a1"},    {16'h0, bus.mem_addr1}, {16'h0, m_a1});
    chk({tag, "_a2"},    {16'h0, bus.mem_addr2}, {16'h0, m_a2});
    chk({tag, "_instr"}, {16'h0, bus.instr},     {16'h0, m_instr});
    chk({tag, "_n"},     {16'h0, bus.n_word},    {16'h0, m_n});
  endtask

  // Starts at a negedge before the first WAIT edge; expects exp_zeros invalid samples.
  task automatic wait_valid(input int exp_zeros, input string tag);
    int zeros = 0;
    bit seen  = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      bus.stall = 1'b0;
      #1;
      if (bus.instr_valid) seen = 1;
      else begin
        zeros++;
        drive_junk(1'b1);
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s_timeout: observed no instr_valid expected instr_valid within 40 cycles", tag);
      finish_run();
    end
    chk({tag, "_wait_len"}, 32'(zeros), 32'(exp_zeros));
    chk({tag, "_halted"}, {31'h0, bus.halted}, 32'h0);
    check_arch(tag);
  endtask

  // Executes the instruction currently presented, after nstall stalled cycles.
  task automatic exec_instr(input string tag, input int nstall, input logic cnt, input logic sload,
                            input logic [15:0] npc, input logic [15:0] a1, input logic [15:0] a2);
    for (int s = 0; s < nstall; s++) begin
      drive_junk(1'b0);
      bus.stall = 1'b1;
      #1;
      chk({tag, "_stall_valid"}, {31'h0, bus.instr_valid}, 32'h0);
      check_arch({tag, "_stall"});
      @(negedge clk);
    end
    bus.stall       = 1'b0;
    bus.cnt_en      = cnt;
    bus.pc_sload    = sload;
    bus.new_pc      = npc;
    bus.instr_addr1 = a1;
    bus.instr_addr2 = a2;
    #1;
    chk({tag, "_valid"}, {31'h0, bus.instr_valid}, 32'h1);
    m_retire++;
    if (m_instr[15:11] == 5'b11111) begin
      @(negedge clk);
      #1;
      chk({tag, "_stp_halted"}, {31'h0, bus.halted}, 32'h1);
      chk({tag, "_stp_valid"}, {31'h0, bus.instr_valid}, 32'h0);
      chk({tag, "_stp_pc"}, {16'h0, bus.pc}, {16'h0, m_pc});
    end else begin
      if (sload)    m_pc = npc;
      else if (cnt) m_pc = m_pc + 16'd1;
      m_a1    = a1;
      m_a2    = a2;
      m_instr = mem[a1];
      m_n     = mem[a2];
      wait_valid(LAT + 1, tag);
    end
  endtask

  task automatic model_reset();
    m_pc     = RST_PC;
    m_a1     = RST_PC;
    m_a2     = RST_PC + 16'd1;
    m_instr  = mem[RST_PC];
    m_n      = mem[RST_PC + 16'd1];
    m_retire = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom) & 16'h7FFF;
    mem[16'h0010] = 16'h7800;
    mem[16'h0011] = 16'h1234;
    rst_n = 1'b0;
    drive_junk(1'b1);
    repeat (3) @(negedge clk);

    #1;
    chk("rst_a1",     {16'h0, bus.mem_addr1}, 32'h0010);
    chk("rst_a2",     {16'h0, bus.mem_addr2}, 32'h0011);
    chk("rst_pc",     {16'h0, bus.pc},        32'h0010);
    chk("rst_instr",  {16'h0, bus.instr},     32'h0000);
    chk("rst_n_word", {16'h0, bus.n_word},    32'h0000);
    chk("rst_valid",  {31'h0, bus.instr_valid}, 32'h0);
    chk("rst_halted", {31'h0, bus.halted},    32'h0);
`ifdef IFETCH_RETIRE_CNT_EN
    chk("rst_retire", bus.retire_cnt, 32'h0);
`endif

    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    wait_valid(LAT, "boot");
    chk("boot_instr_const", {16'h0, bus.instr}, 32'h7800);
    chk("boot_n_const",     {16'h0, bus.n_word}, 32'h1234);

    exec_instr("stall3", 3, 1'b1, 1'b0, 16'h0000, 16'h0100, 16'h0101);
    exec_instr("jump_ffff", 0, 1'b0, 1'b1, 16'hFFFF, 16'h0200, 16'h0201);
    exec_instr("wrap", 0, 1'b1, 1'b0, 16'h1111, 16'h0000, 16'h0001);
    chk("wrap_pc_const", {16'h0, bus.pc}, 32'h0000);
    exec_instr("ld_prio", 0, 1'b1, 1'b1, 16'h0041, 16'h0040, 16'h0041);
    chk("ld_prio_pc_const", {16'h0, bus.pc}, 32'h0041);
    exec_instr("hold", 1, 1'b0, 1'b0, 16'hABCD, 16'h0300, 16'h0305);

    for (int r = 0; r < 25; r++) begin
      logic [15:0] a1, a2;
      a1 = 16'($urandom);
      a2 = 16'($urandom);
      if (a1 == 16'h2000) a1 = 16'h2001;
      exec_instr("rand", $urandom_range(0, 2), 1'($urandom), 1'($urandom), 16'($urandom), a1, a2);
    end

    mem[16'h2000] = 16'hF800;
    exec_instr("to_stp", 0, 1'b0, 1'b1, 16'h2000, 16'h2000, 16'h2001);
    exec_instr("stp", 0, 1'b1, 1'b1, 16'h5555, 16'h0400, 16'h0401);
`ifdef IFETCH_RETIRE_CNT_EN
    chk("retire_total", bus.retire_cnt, 32'(m_retire));
`endif

    for (int h = 0; h < 20; h++) begin
      drive_junk(1'b1);
      @(negedge clk);
      #1;
      chk("halt_halted", {31'h0, bus.halted}, 32'h1);
      chk("halt_valid",  {31'h0, bus.instr_valid}, 32'h0);
      chk("halt_pc",     {16'h0, bus.pc}, {16'h0, m_pc});
      chk("halt_a1",     {16'h0, bus.mem_addr1}, {16'h0, m_a1});
    end

    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_halted", {31'h0, bus.halted}, 32'h0);
    chk("mid_rst_valid",  {31'h0, bus.instr_valid}, 32'h0);
    chk("mid_rst_pc",     {16'h0, bus.pc}, {16'h0, m_pc});
    chk("mid_rst_a1",     {16'h0, bus.mem_addr1}, {16'h0, m_a1});
    chk("mid_rst_a2",     {16'h0, bus.mem_addr2}, {16'h0, m_a2});
    chk("mid_rst_instr",  {16'h0, bus.instr}, 32'h0000);
`ifdef IFETCH_RETIRE_CNT_EN
    chk("mid_rst_retire", bus.retire_cnt, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(LAT, "reboot");

    for (int r = 0; r < 5; r++) begin
      exec_instr("post", 0, 1'b1, 1'b0, 16'h0000, 16'(16'h0500 + 16'(2 * r)), 16'(16'h0501 + 16'(2 * r)));
    end
`ifdef IFETCH_RETIRE_CNT_EN
    chk("retire_five", bus.retire_cnt, 32'd5);
`endif

    finish_run();
  end

endmodule
